// File: rtl/matrix_scan_pkg.sv
// Shared types and helpers for the LED matrix scan controller:
// scan state encoding, frame-buffer bit addressing and pin polarity.
package matrix_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_e;

  // Widest row/column word the polarity helper handles.
  localparam int MAX_W = 64;

  function automatic int flat_index(input int page, input int col, input int row,
                                    input int cols, input int rows);
    return ((page * cols) + col) * rows + row;
  endfunction

  function automatic logic [MAX_W-1:0] apply_polarity(input logic [MAX_W-1:0] active_word,
                                                      input logic active_low);
    logic [MAX_W-1:0] pin_word;
    if (active_low) begin
      pin_word = ~active_word;
    end else begin
      pin_word = active_word;
    end
    return pin_word;
  endfunction

endpackage

// File: rtl/matrix_scan_controller_scan_timer.sv
// Column slot counter: counts SCAN_DIV cycles per slot and flags the last
// blank cycle and the last drive cycle of each slot.
module scan_timer #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic blank_done,
  output logic drive_done,
  output logic drive_last_next
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;

  // Next slot count: cleared on enable drop, wraps at end of slot.
  always_comb begin
    cnt_next_s = cnt_r;
    if (clear) begin
      cnt_next_s = '0;
    end else if (run) begin
      if (cnt_r == CNT_LAST) begin
        cnt_next_s = '0;
      end else begin
        cnt_next_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Slot count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign blank_done      = (BLANK_CYCLES > 0) && (cnt_r == BLANK_LAST);
  assign drive_done      = (cnt_r == CNT_LAST);
  // Lets the parent register a pulse that lines up with the last drive cycle.
  assign drive_last_next = (cnt_next_s == CNT_LAST);

endmodule

// File: rtl/matrix_scan_controller.sv
// Multiplexed COLS x ROWS LED matrix scanner with per-slot blanking and
// automatic rotation through PAGES frame buffers.
module matrix_scan_controller
  import matrix_scan_pkg::*;
#(
  parameter int COLS           = 5,
  parameter int ROWS           = 7,
  parameter int PAGES          = 2,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 4,
  parameter int PAGE_HOLD      = 200,
  parameter int COL_ACTIVE_LOW = 1,
  parameter int ROW_ACTIVE_LOW = 0
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        enable,
  input  logic                                        freeze,
  input  logic [PAGES*COLS*ROWS-1:0]                  page_data,
  output logic [COLS-1:0]                             matrix_col,
  output logic [ROWS-1:0]                             matrix_row,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0]   column_index,
  output logic [((PAGES > 1) ? $clog2(PAGES) : 1)-1:0] page_index,
  output logic                                        frame_tick
);

  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PAGE_W  = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int FRAME_W = $clog2(PAGE_HOLD + 1);
  localparam int DATA_W  = PAGES * COLS * ROWS;
  localparam int IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0]   COL_ONE    = COL_W'(1);
  localparam logic [PAGE_W-1:0]  PAGE_LAST  = PAGE_W'(PAGES - 1);
  localparam logic [PAGE_W-1:0]  PAGE_ONE   = PAGE_W'(1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(PAGE_HOLD - 1);
  localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);

  localparam logic COL_LOW = (COL_ACTIVE_LOW != 0);
  localparam logic ROW_LOW = (ROW_ACTIVE_LOW != 0);
  localparam logic [MAX_W-1:0] COL_OFF_W = apply_polarity({MAX_W{1'b0}}, COL_LOW);
  localparam logic [MAX_W-1:0] ROW_OFF_W = apply_polarity({MAX_W{1'b0}}, ROW_LOW);
  localparam logic [COLS-1:0]  COL_OFF   = COL_OFF_W[COLS-1:0];
  localparam logic [ROWS-1:0]  ROW_OFF   = ROW_OFF_W[ROWS-1:0];

  scan_state_e         state_r;
  scan_state_e         state_next_s;
  logic [COL_W-1:0]    col_r;
  logic [COL_W-1:0]    col_next_s;
  logic [PAGE_W-1:0]   page_r;
  logic [PAGE_W-1:0]   page_next_s;
  logic [FRAME_W-1:0]  frame_cnt_r;
  logic [FRAME_W-1:0]  frame_cnt_next_s;
  logic                frame_event_s;
  logic                drive_entry_s;
  logic [ROWS-1:0]     row_sample_s;
  logic [MAX_W-1:0]    col_word_s;
  logic [MAX_W-1:0]    row_word_s;
  logic [MAX_W-1:0]    col_pins_s;
  logic [MAX_W-1:0]    row_pins_s;
  logic [COLS-1:0]     matrix_col_r;
  logic [ROWS-1:0]     matrix_row_r;
  logic                frame_tick_r;
  logic                blank_done_s;
  logic                drive_done_s;
  logic                drive_last_next_s;

  scan_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_scan_timer (
    .clock           (clock),
    .reset           (reset),
    .run             (state_r != IDLE),
    .clear           (!enable),
    .blank_done      (blank_done_s),
    .drive_done      (drive_done_s),
    .drive_last_next (drive_last_next_s)
  );

  // Scan sequencing: state and column advance, end-of-frame detection.
  always_comb begin
    state_next_s  = state_r;
    col_next_s    = col_r;
    frame_event_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_next_s = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
        end else begin
          state_next_s = IDLE;
        end
      end
      BLANK: begin
        if (!enable) begin
          state_next_s = IDLE;
        end else if (blank_done_s) begin
          state_next_s = DRIVE;
        end else begin
          state_next_s = BLANK;
        end
      end
      DRIVE: begin
        if (!enable) begin
          state_next_s = IDLE;
        end else if (drive_done_s) begin
          state_next_s  = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
          col_next_s    = (col_r == COL_LAST) ? '0 : (col_r + COL_ONE);
          frame_event_s = (col_r == COL_LAST);
        end else begin
          state_next_s = DRIVE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Page rotation after PAGE_HOLD frames unless frozen.
  always_comb begin
    page_next_s      = page_r;
    frame_cnt_next_s = frame_cnt_r;
    if (frame_event_s && !freeze) begin
      if (frame_cnt_r == FRAME_LAST) begin
        frame_cnt_next_s = '0;
        page_next_s      = (page_r == PAGE_LAST) ? '0 : (page_r + PAGE_ONE);
      end else begin
        frame_cnt_next_s = frame_cnt_r + FRAME_ONE;
      end
    end else begin
      page_next_s      = page_r;
      frame_cnt_next_s = frame_cnt_r;
    end
  end

  // Row data and column select for the slot about to enter its drive phase;
  // next-state indices keep the zero-blank case on the right column and page.
  always_comb begin
    drive_entry_s = (state_next_s == DRIVE) && ((state_r != DRIVE) || drive_done_s);
    row_sample_s  = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_sample_s[r] = page_data[IDX_W'(flat_index(int'(page_next_s), int'(col_next_s),
                                                    r, COLS, ROWS))];
    end
    col_word_s             = {{(MAX_W-1){1'b0}}, 1'b1} << col_next_s;
    row_word_s             = '0;
    row_word_s[ROWS-1:0]   = row_sample_s;
    col_pins_s             = apply_polarity(col_word_s, COL_LOW);
    row_pins_s             = apply_polarity(row_word_s, ROW_LOW);
  end

  // State, indices and registered pin drive; column and rows change on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      col_r        <= '0;
      page_r       <= '0;
      frame_cnt_r  <= '0;
      matrix_col_r <= COL_OFF;
      matrix_row_r <= ROW_OFF;
      frame_tick_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      col_r        <= col_next_s;
      page_r       <= page_next_s;
      frame_cnt_r  <= frame_cnt_next_s;
      frame_tick_r <= (state_next_s == DRIVE) && (col_next_s == COL_LAST) && drive_last_next_s;
      if (state_next_s != DRIVE) begin
        matrix_col_r <= COL_OFF;
        matrix_row_r <= ROW_OFF;
      end else if (drive_entry_s) begin
        matrix_col_r <= col_pins_s[COLS-1:0];
        matrix_row_r <= row_pins_s[ROWS-1:0];
      end else begin
        matrix_col_r <= matrix_col_r;
        matrix_row_r <= matrix_row_r;
      end
    end
  end

  assign matrix_col   = matrix_col_r;
  assign matrix_row   = matrix_row_r;
  assign column_index = col_r;
  assign page_index   = page_r;
  assign frame_tick   = frame_tick_r;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Directed bench for matrix_scan_controller: 5x7 matrix, 2 pages,
// 8-cycle slots with 2 blank cycles, pages held for 2 frames.
module tb_matrix_scan_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        freeze;
  logic [69:0] page_data;
  logic [4:0]  matrix_col;
  logic [6:0]  matrix_row;
  logic [2:0]  column_index;
  logic [0:0]  page_index;
  logic        frame_tick;

  int passed = 0;
  int total  = 0;
  int n;

  always #5 clock = ~clock;

  matrix_scan_controller #(
    .COLS(5), .ROWS(7), .PAGES(2), .SCAN_DIV(8), .BLANK_CYCLES(2),
    .PAGE_HOLD(2), .COL_ACTIVE_LOW(1), .ROW_ACTIVE_LOW(0)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .freeze       (freeze),
    .page_data    (page_data),
    .matrix_col   (matrix_col),
    .matrix_row   (matrix_row),
    .column_index (column_index),
    .page_index   (page_index),
    .frame_tick   (frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      step(1);
      cnt++;
    end while (frame_tick !== 1'b1 && cnt < 200);
  endtask

  task automatic set_col(input int p, input int c, input logic [6:0] v);
    page_data[p*35 + c*7 +: 7] = v;
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    freeze    = 1'b0;
    page_data = '0;
    set_col(0, 0, 7'b0000001); set_col(0, 1, 7'b0000011); set_col(0, 2, 7'b1010101);
    set_col(0, 3, 7'b1110000); set_col(0, 4, 7'b0101010);
    set_col(1, 0, 7'h7F); set_col(1, 1, 7'h40); set_col(1, 2, 7'h22);
    set_col(1, 3, 7'h0F); set_col(1, 4, 7'h11);
    step(2);
    check("rst_col", 32'(matrix_col), 32'h1F);
    check("rst_row", 32'(matrix_row), 32'h00);
    check("rst_cidx", 32'(column_index), 32'd0);
    check("rst_pidx", 32'(page_index), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);

    // Start scanning: two blank cycles, then column 0.
    reset  = 1'b0;
    enable = 1'b1;
    step(1); check("blank1_col", 32'(matrix_col), 32'h1F);
    step(1); check("blank2_col", 32'(matrix_col), 32'h1F);
    step(1); check("c0_col", 32'(matrix_col), 32'h1E);
             check("c0_row", 32'(matrix_row), 32'h01);
             check("c0_cidx", 32'(column_index), 32'd0);
    step(6); check("s1_blank_col", 32'(matrix_col), 32'h1F);
             check("s1_cidx", 32'(column_index), 32'd1);
    step(10); check("c2_col", 32'(matrix_col), 32'h1B);
              check("c2_row", 32'(matrix_row), 32'h55);
              check("c2_cidx", 32'(column_index), 32'd2);
    step(5); check("c2_last_row", 32'(matrix_row), 32'h55);
    step(1); check("s3_blank_col", 32'(matrix_col), 32'h1F);
             check("s3_blank_row", 32'(matrix_row), 32'h00);

    // Change page 0 columns 3 and 4 in the middle of column 3's drive.
    step(3); check("c3_col", 32'(matrix_col), 32'h17);
             check("c3_row", 32'(matrix_row), 32'h70);
    set_col(0, 3, 7'b0000111);
    set_col(0, 4, 7'b0011001);
    step(1); check("c3_hold_row_a", 32'(matrix_row), 32'h70);
    step(3); check("c3_hold_row_b", 32'(matrix_row), 32'h70);
             check("c3_hold_col", 32'(matrix_col), 32'h17);
    step(1); check("s4_blank_col", 32'(matrix_col), 32'h1F);
    step(2); check("c4_col", 32'(matrix_col), 32'h0F);
             check("c4_new_row", 32'(matrix_row), 32'h19);
    step(4); check("tick_before", 32'(frame_tick), 32'd0);
    step(1); check("tick_first", 32'(frame_tick), 32'd1);
             check("tick_first_pidx", 32'(page_index), 32'd0);

    // Rotation: page flips after the second frame.
    wait_tick(n); check("frame_period", 32'(n), 32'd40);
    check("pidx_before_flip", 32'(page_index), 32'd0);
    step(1); check("pidx_flip", 32'(page_index), 32'd1);
             check("tick_one_cycle", 32'(frame_tick), 32'd0);
    step(2); check("p1c0_col", 32'(matrix_col), 32'h1E);
             check("p1c0_row", 32'(matrix_row), 32'h7F);

    // Drop enable during column 3 drive, then resume.
    step(25); check("p1c3_col", 32'(matrix_col), 32'h17);
              check("p1c3_row", 32'(matrix_row), 32'h0F);
    enable = 1'b0;
    step(1); check("dis_col", 32'(matrix_col), 32'h1F);
             check("dis_row", 32'(matrix_row), 32'h00);
             check("dis_cidx", 32'(column_index), 32'd3);
             check("dis_pidx", 32'(page_index), 32'd1);
    step(3); check("dis_hold_col", 32'(matrix_col), 32'h1F);
    enable = 1'b1;
    step(1); check("re_blank1_col", 32'(matrix_col), 32'h1F);
    step(1); check("re_blank2_col", 32'(matrix_col), 32'h1F);
    step(1); check("re_c3_col", 32'(matrix_col), 32'h17);
             check("re_c3_row", 32'(matrix_row), 32'h0F);
             check("re_c3_cidx", 32'(column_index), 32'd3);
             check("re_c3_pidx", 32'(page_index), 32'd1);
    wait_tick(n); check("re_tick_delay", 32'(n), 32'd13);
    wait_tick(n); check("re_frame_period", 32'(n), 32'd40);
    step(1); check("pidx_back0", 32'(page_index), 32'd0);

    // Freeze over five frames: page holds, ticks continue.
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_tick(n); check("frz_period", 32'(n), 32'd39);
      step(1); check("frz_pidx", 32'(page_index), 32'd0);
    end
    freeze = 1'b0;
    wait_tick(n); check("unfrz_period", 32'(n), 32'd39);
    step(1); check("unfrz_pidx_a", 32'(page_index), 32'd0);
    wait_tick(n); check("unfrz_period2", 32'(n), 32'd39);
    step(1); check("unfrz_pidx_b", 32'(page_index), 32'd1);

    // Asynchronous reset in the middle of a drive phase.
    step(2); check("pre_rst_col", 32'(matrix_col), 32'h1E);
             check("pre_rst_row", 32'(matrix_row), 32'h7F);
    reset = 1'b1;
    #1;
    check("arst_col", 32'(matrix_col), 32'h1F);
    check("arst_row", 32'(matrix_row), 32'h00);
    check("arst_pidx", 32'(page_index), 32'd0);
    step(2);
    reset = 1'b0;
    step(1); check("post_rst_blank1", 32'(matrix_col), 32'h1F);
    step(1); check("post_rst_blank2", 32'(matrix_col), 32'h1F);
    step(1); check("post_rst_col", 32'(matrix_col), 32'h1E);
             check("post_rst_row", 32'(matrix_row), 32'h01);
             check("post_rst_pidx", 32'(page_index), 32'd0);
             check("post_rst_cidx", 32'(column_index), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/matrix_scan_controller.md
Name: matrix_scan_controller

Overview:
Parametrised successor to the fixed 5x7 matrix column scanner used for the water/irrigation status display. It time-multiplexes a COLS x ROWS LED matrix from a prescaled tick and inserts a blanking gap between columns to suppress ghosting. It rotates automatically through PAGES frame buffers (for example water level, then irrigation mode), and a freeze input holds the current page. It sits between the status encoders/decoders and the matrix pins, replacing the separate clock divider, column selector and display selector.

Parameters:
COLS, 5, number of matrix columns (scanned), >=1
ROWS, 7, number of matrix rows (driven per column), >=1
PAGES, 2, number of frame buffers rotated, >=1
SCAN_DIV, 50000, clock cycles per column slot (blank + drive), > BLANK_CYCLES
BLANK_CYCLES, 4, cycles at the start of each slot with all LEDs off, >=0
PAGE_HOLD, 200, full frames shown per page before advancing, >=1
COL_ACTIVE_LOW, 1, 1 = selected column pin driven 0
ROW_ACTIVE_LOW, 0, 1 = lit row pin driven 0

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  scanning enabled
freeze  in  1  hold current page, no rotation
page_data  in  PAGES*COLS*ROWS  frame buffers; bit p*COLS*ROWS + c*ROWS + r = LED (column c, row r) of page p, 1 = lit
matrix_col  out  COLS  column drive, polarity per COL_ACTIVE_LOW
matrix_row  out  ROWS  row drive, polarity per ROW_ACTIVE_LOW
column_index  out  clog2(COLS) (min 1)  column currently in slot
page_index  out  clog2(PAGES) (min 1)  page currently displayed
frame_tick  out  1  one-cycle pulse at end of last column's drive phase

Behaviour:
- Reset is asynchronous, active-high. On reset: state IDLE, slot counter 0, column_index 0, page_index 0, frame counter 0, frame_tick 0. matrix_col and matrix_row take their inactive levels (all columns deselected, all rows dark).
- States: IDLE, BLANK, DRIVE. All outputs are registered.
- IDLE: outputs inactive. When enable=1, go to BLANK on the next cycle, or straight to DRIVE if BLANK_CYCLES=0.
- BLANK: lasts exactly BLANK_CYCLES cycles; all columns and rows inactive; then DRIVE.
- Column data for DRIVE is sampled on the BLANK->DRIVE transition edge (or the IDLE->DRIVE edge). It is held constant for the whole drive phase; page_data changes mid-slot have no effect until the next slot.
- DRIVE: lasts SCAN_DIV-BLANK_CYCLES cycles. Exactly one column is active (column_index), and rows show the sampled bits. At the end of DRIVE, column_index wraps from COLS-1 to 0, otherwise increments; then BLANK.
- frame_tick: asserted for the single cycle in which DRIVE of column COLS-1 ends.
- Page rotation: the frame counter increments on each frame_tick. When it reaches PAGE_HOLD, the counter clears and page_index advances (PAGES-1 wraps to 0); the new page takes effect from the next slot.
- freeze=1: frame counter and page_index hold. Scanning continues.
- PAGES=1: page_index is constant 0.
- enable deasserted: next cycle IDLE, outputs inactive, slot counter cleared. column_index, page_index and frame counter are retained. Re-enable resumes with a full BLANK of the retained column.
- Reset mid-slot: immediate inactive outputs. The first slot after release is column 0, page 0.
- Invariant: at most one column active in any cycle; no cycle has the old column active with new row data.

Decomposition:
- Package matrix_scan_pkg: state enum (IDLE, BLANK, DRIVE); function giving the flat bit index from (page, col, row); polarity helper that applies the active-low flags.
- Sub-module scan_timer: slot counter producing blank_done/drive_done strobes from SCAN_DIV/BLANK_CYCLES, with a synchronous clear for enable drop.

Test Plan:
Use COLS=5, ROWS=7, PAGES=2, SCAN_DIV=8, BLANK_CYCLES=2, PAGE_HOLD=2, COL_ACTIVE_LOW=1, ROW_ACTIVE_LOW=0.
- Reset asserted during DRIVE -> same cycle matrix_col=5'b11111, matrix_row=0. After release with enable=1: 2 blank cycles, then column 0 is driven (matrix_col=5'b11110).
- Page 0 column 2 = 7'b1010101 -> in slot 2, 2 cycles all-off, then 6 cycles of matrix_col=5'b11011, matrix_row=7'b1010101. Slot period is 8 cycles.
- Free run -> frame_tick every 40 cycles. page_index goes 0->1 after 2 frame_ticks, and back to 0 after 4.
- freeze=1 over 5 frames -> page_index constant, frame_tick still every 40 cycles.
- Change page_data in mid-DRIVE -> rows unchanged until the next slot's drive phase.
- enable dropped during column 3 drive -> next cycle outputs inactive. On re-enable: 2 blank cycles, then column 3 driven with the same page_index.
